// File: rtl/debounce_multi.sv
// Multi-channel presence/button debouncer: per-channel counter with separate
// rise/fall thresholds, optional leaky integration, and registered edge events.
module debounce_multi #(
  parameter int CH       = 4,
  parameter int CNT_W    = 4,
  parameter int RISE_CNT = 4,
  parameter int FALL_CNT = 4,
  parameter int LEAKY    = 0
) (
  input  logic          clk_1k,
  input  logic          cpld_rst_n,
  input  logic          db_bypass,
  input  logic [CH-1:0] prsnt_in,
  output logic [CH-1:0] prsnt_out,
  output logic [CH-1:0] rise_evt,
  output logic [CH-1:0] fall_evt,
  output logic          any_change
);

  // One extra bit so the compare against T never aliases on wrap-around.
  localparam logic [CNT_W:0] RISE_T = (CNT_W+1)'(RISE_CNT);
  localparam logic [CNT_W:0] FALL_T = (CNT_W+1)'(FALL_CNT);

  logic [CH-1:0][CNT_W-1:0] cnt_p0;
  logic [CH-1:0][CNT_W-1:0] cnt_nxt;
  logic [CH-1:0]            out_nxt;

  function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] c);
    return {1'b0, c} + (CNT_W+1)'(1);
  endfunction

  // Matching sample: hard clear, or decay by one with a floor of zero.
  function automatic logic [CNT_W-1:0] cnt_match(input logic [CNT_W-1:0] c);
    if (LEAKY != 0 && c != '0) return c - CNT_W'(1);
    return '0;
  endfunction

  always_comb begin
    logic [CNT_W:0] inc;
    logic [CNT_W:0] thr;
    inc     = '0;
    thr     = '0;
    out_nxt = prsnt_out;
    cnt_nxt = '0;
    if (db_bypass) begin
      out_nxt = prsnt_in;
    end else begin
      for (int i = 0; i < CH; i++) begin
        thr = prsnt_in[i] ? RISE_T : FALL_T;
        if (prsnt_in[i] != prsnt_out[i]) begin
          inc = cnt_inc(cnt_p0[i]);
          if (inc == thr) out_nxt[i] = prsnt_in[i];
          else            cnt_nxt[i] = inc[CNT_W-1:0];
        end else begin
          cnt_nxt[i] = cnt_match(cnt_p0[i]);
        end
      end
    end
  end

  // Stage p0 -> registered outputs; events compare the next level to the current one.
  always_ff @(posedge clk_1k or negedge cpld_rst_n) begin
    if (!cpld_rst_n) begin
      prsnt_out  <= prsnt_in;
      cnt_p0     <= '0;
      rise_evt   <= '0;
      fall_evt   <= '0;
      any_change <= 1'b0;
    end else begin
      prsnt_out  <= out_nxt;
      cnt_p0     <= cnt_nxt;
      rise_evt   <= out_nxt & ~prsnt_out;
      fall_evt   <= ~out_nxt & prsnt_out;
      any_change <= |(out_nxt ^ prsnt_out);
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three parameterisations against a history-based model.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bypass;
  logic [3:0] pin;

  logic [3:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b, out_c, rise_c, fall_c;
  logic       any_a, any_b, any_c;

  always #5 clk = ~clk;

  debounce_multi #(.CH(4), .CNT_W(4), .RISE_CNT(4), .FALL_CNT(4), .LEAKY(0)) dut_a (
    .clk_1k(clk), .cpld_rst_n(rst_n), .db_bypass(bypass), .prsnt_in(pin),
    .prsnt_out(out_a), .rise_evt(rise_a), .fall_evt(fall_a), .any_change(any_a));
  debounce_multi #(.CH(4), .CNT_W(4), .RISE_CNT(4), .FALL_CNT(4), .LEAKY(1)) dut_b (
    .clk_1k(clk), .cpld_rst_n(rst_n), .db_bypass(bypass), .prsnt_in(pin),
    .prsnt_out(out_b), .rise_evt(rise_b), .fall_evt(fall_b), .any_change(any_b));
  debounce_multi #(.CH(4), .CNT_W(4), .RISE_CNT(2), .FALL_CNT(8), .LEAKY(0)) dut_c (
    .clk_1k(clk), .cpld_rst_n(rst_n), .db_bypass(bypass), .prsnt_in(pin),
    .prsnt_out(out_c), .rise_evt(rise_c), .fall_evt(fall_c), .any_change(any_c));

  int checks = 0;
  int errors = 0;

  int rise_t[3] = '{4, 4, 2};
  int fall_t[3] = '{4, 4, 8};
  int leak_m[3] = '{0, 1, 0};

  // Model: every sample seen since the last output flip (or reset/bypass) is kept.
  bit [3:0] m_out[3];
  bit [3:0] m_rise[3];
  bit [3:0] m_fall[3];
  bit       m_any[3];
  bit       samp[3][4][8192];
  int       slen[3][4];

  function automatic bit flips(int k, int c);
    bit o = m_out[k][c];
    int t = o ? fall_t[k] : rise_t[k];
    int s = 0;
    if (leak_m[k] != 0) begin
      for (int j = 0; j < slen[k][c]; j++) begin
        if (samp[k][c][j] != o) s++;
        else if (s > 0) s--;
      end
    end else begin
      for (int j = slen[k][c] - 1; j >= 0; j--) begin
        if (samp[k][c][j] == o) break;
        s++;
      end
    end
    return s >= t;
  endfunction

  initial begin
    bit [3:0] prev;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) begin
        prev = m_out[k];
        if (!rst_n) begin
          m_out[k] = pin;
          for (int c = 0; c < 4; c++) slen[k][c] = 0;
          m_rise[k] = '0;
          m_fall[k] = '0;
          m_any[k]  = 1'b0;
        end else begin
          if (bypass) begin
            m_out[k] = pin;
            for (int c = 0; c < 4; c++) slen[k][c] = 0;
          end else begin
            for (int c = 0; c < 4; c++) begin
              if (slen[k][c] < 8192) begin
                samp[k][c][slen[k][c]] = pin[c];
                slen[k][c]++;
              end
              if (flips(k, c)) begin
                m_out[k][c] = ~m_out[k][c];
                slen[k][c]  = 0;
              end
            end
          end
          m_rise[k] = m_out[k] & ~prev;
          m_fall[k] = ~m_out[k] & prev;
          m_any[k]  = |(m_out[k] ^ prev);
        end
      end
    end
  end

  function automatic logic [12:0] actual(int k);
    case (k)
      0:       return {out_a, rise_a, fall_a, any_a};
      1:       return {out_b, rise_b, fall_b, any_b};
      default: return {out_c, rise_c, fall_c, any_c};
    endcase
  endfunction

  bit          lit_on = 1'b0;
  int          lit_k;
  string       lit_name;
  logic [12:0] lit_exp;

  // Single compare process: model every cycle, plus literal expectations when posted.
  initial begin
    logic [12:0] act;
    logic [12:0] exp_v;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        act   = actual(k);
        exp_v = {m_out[k], m_rise[k], m_fall[k], m_any[k]};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t got out/rise/fall/any=%h want=%h", k, $time, act, exp_v);
        end
      end
      if (lit_on) begin
        act = actual(lit_k);
        checks++;
        if (act !== lit_exp) begin
          errors++;
          $display("FAIL %s dut%0d t=%0t got out/rise/fall/any=%h want=%h", lit_name, lit_k, $time, act, lit_exp);
        end
      end
    end
  end

  task automatic check_lit(input int k, input string name, input logic [3:0] o,
                           input logic [3:0] r, input logic [3:0] f, input logic a);
    lit_k    = k;
    lit_name = name;
    lit_exp  = {o, r, f, a};
    lit_on   = 1'b1;
    @(negedge clk);
    #1;
    lit_on   = 1'b0;
  endtask

  task automatic edge_with(input logic [3:0] v);
    pin = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    repeat (n) edge_with(v);
  endtask

  initial begin
    logic [3:0] v;
    int rate;
    pin    = 4'b1010;
    rst_n  = 1'b0;
    bypass = 1'b0;

    // Reset capture and quiet release
    hold(4'b1010, 3);
    check_lit(0, "in_reset", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    hold(4'b1010, 20);
    check_lit(0, "reset_release", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // Default thresholds on ch0
    hold(4'b1011, 3);
    check_lit(0, "rise_edge3", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    edge_with(4'b1011);
    check_lit(0, "rise_edge4", 4'b1011, 4'b0001, 4'b0000, 1'b1);
    edge_with(4'b1011);
    check_lit(0, "rise_pulse_end", 4'b1011, 4'b0000, 4'b0000, 1'b0);
    hold(4'b1011, 8);
    hold(4'b1010, 4);
    check_lit(0, "fall_edge4", 4'b1010, 4'b0000, 4'b0001, 1'b1);
    hold(4'b1010, 10);

    // Clear vs leaky counting on ch1
    hold(4'b1000, 10);
    edge_with(4'b1010); edge_with(4'b1010); edge_with(4'b1010);
    edge_with(4'b1000); edge_with(4'b1010); edge_with(4'b1010);
    check_lit(1, "leaky_flip", 4'b1010, 4'b0010, 4'b0000, 1'b1);
    edge_with(4'b1010);
    check_lit(0, "clear_no_flip", 4'b1000, 4'b0000, 4'b0000, 1'b0);
    hold(4'b1000, 10);
    hold(4'b1010, 4);
    check_lit(0, "clear_flip", 4'b1010, 4'b0010, 4'b0000, 1'b1);
    hold(4'b1010, 10);

    // Asymmetric thresholds on ch2
    hold(4'b1110, 2);
    check_lit(2, "asym_rise2", 4'b1110, 4'b0100, 4'b0000, 1'b1);
    hold(4'b1110, 4);
    hold(4'b1010, 7);
    edge_with(4'b1110);
    check_lit(2, "asym_reject7", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    hold(4'b1010, 8);
    check_lit(2, "asym_fall8", 4'b1010, 4'b0000, 4'b0100, 1'b1);

    // Simultaneous flips on ch0 and ch3
    hold(4'b0000, 10);
    hold(4'b1001, 4);
    check_lit(0, "multi_flip", 4'b1001, 4'b1001, 4'b0000, 1'b1);
    edge_with(4'b1001);
    check_lit(0, "multi_pulse_end", 4'b1001, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-count, then bypass glitch
    hold(4'b0000, 10);
    hold(4'b0110, 2);
    rst_n = 1'b0;
    check_lit(0, "reset_midcount", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    hold(4'b0110, 2);
    rst_n = 1'b1;
    hold(4'b0110, 3);
    check_lit(0, "after_midcount", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    hold(4'b0000, 10);
    bypass = 1'b1;
    edge_with(4'b0000);
    edge_with(4'b0001);
    check_lit(0, "bypass_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    edge_with(4'b0000);
    check_lit(1, "bypass_fall", 4'b0000, 4'b0000, 4'b0001, 1'b1);
    edge_with(4'b0000);
    check_lit(2, "bypass_quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    bypass = 1'b0;

    // Randomised traffic with occasional bypass and reset
    rate = 6;
    v    = pin;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) rate = int'($urandom_range(2, 14));
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, rate - 1) == 0) v[b] = ~v[b];
      if ($urandom_range(0, 199) == 0) bypass = ~bypass;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      edge_with(v);
    end
    rst_n  = 1'b1;
    bypass = 1'b0;
    hold(v, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
